// File: rtl/bp_pkg.sv
// Shared types and defaults for the gshare branch predictor front end:
// PHT counter encodings and the in-flight branch record.
package bp_pkg;

    localparam int BP_IDX_W = 3;
    localparam int BP_DEPTH = 4;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } pht_ctr_e;

    typedef struct packed {
        logic [BP_IDX_W-1:0] index;
        logic                pred;
    } bp_entry_t;

    // The direction bit of a 2-bit saturating counter is its MSB.
    function automatic logic ctr_taken(input pht_ctr_e ctr);
        return ctr[1];
    endfunction

endpackage

// File: rtl/bp_inflight_fifo.sv
// In-order queue of predicted-but-unresolved branches; supports push, pop
// and a whole-queue flush for mispredict recovery.
module bp_inflight_fifo
    import bp_pkg::*;
#(
    parameter int  DEPTH   = BP_DEPTH,
    parameter type entry_t = bp_entry_t,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  entry_t           push_entry,
    input  logic             pop,
    input  logic             flush,
    output entry_t           head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] occupancy
);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign occupancy = count;
    assign head      = mem[rd_ptr];
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;

    // NOTE: storage has no reset; validity is tracked by count, so stale data is never observed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gshare_update_ctrl.sv
// gshare front end and retirement: hashes pc with speculative history, tracks
// in-flight predictions, issues PHT updates and repairs history on mispredict.
module gshare_update_ctrl
    import bp_pkg::*;
#(
    parameter int IDX_W = BP_IDX_W,
    parameter int DEPTH = BP_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   pred_valid,
    input  logic [IDX_W-1:0]       pred_pc,
    output logic                   pred_ready,
    output logic [IDX_W-1:0]       pht_rd_index,
    input  logic [1:0]             pht_rd_counter,
    output logic                   pred_taken,
    input  logic                   res_valid,
    input  logic                   res_taken,
    output logic                   mispredict,
    output logic                   pht_update_en,
    output logic [IDX_W-1:0]       pht_update_index,
    output logic                   pht_actual,
    output logic [IDX_W-1:0]       spec_ghr,
    output logic [IDX_W-1:0]       arch_ghr,
    output logic [$clog2(DEPTH):0] occupancy
);

    typedef struct packed {
        logic [IDX_W-1:0] index;
        logic             pred;
    } entry_t;

    entry_t           head;
    entry_t           push_entry;
    logic             full;
    logic             empty;
    logic             resolve;
    logic             head_mis;
    logic             accept;
    logic [IDX_W-1:0] arch_next;

    assign pht_rd_index = pred_pc ^ spec_ghr;
    assign pred_taken   = ctr_taken(pht_ctr_e'(pht_rd_counter));

    // A mispredicting head flushes the queue this edge, so new pushes are refused.
    assign resolve    = res_valid & ~empty;
    assign head_mis   = resolve & (head.pred != res_taken);
    assign pred_ready = ~full & ~head_mis;
    assign accept     = pred_valid & pred_ready;
    assign arch_next  = {arch_ghr[IDX_W-2:0], res_taken};
    assign push_entry = '{index: pht_rd_index, pred: pred_taken};

    bp_inflight_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (accept),
        .push_entry (push_entry),
        .pop        (resolve),
        .flush      (head_mis),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .occupancy  (occupancy)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spec_ghr         <= '0;
            arch_ghr         <= '0;
            mispredict       <= 1'b0;
            pht_update_en    <= 1'b0;
            pht_update_index <= '0;
            pht_actual       <= 1'b0;
        end else begin
            mispredict    <= head_mis;
            pht_update_en <= resolve;
            if (resolve) begin
                arch_ghr         <= arch_next;
                pht_update_index <= head.index;
                pht_actual       <= res_taken;
            end
            // Repair takes priority; accept is already blocked on a mispredict.
            if (head_mis) begin
                spec_ghr <= arch_next;
            end else if (accept) begin
                spec_ghr <= {spec_ghr[IDX_W-2:0], pred_taken};
            end
        end
    end

endmodule

// File: tb/tb_gshare_update_ctrl.sv
// Directed bench for gshare_update_ctrl: expected PHT updates are queued at
// resolve time and matched by a monitor; state is checked against hand values.
module tb_gshare_update_ctrl;

    logic       clk;
    logic       reset_n;
    logic       pred_valid;
    logic [2:0] pred_pc;
    logic       pred_ready;
    logic [2:0] pht_rd_index;
    logic [1:0] pht_rd_counter;
    logic       pred_taken;
    logic       res_valid;
    logic       res_taken;
    logic       mispredict;
    logic       pht_update_en;
    logic [2:0] pht_update_index;
    logic       pht_actual;
    logic [2:0] spec_ghr;
    logic [2:0] arch_ghr;
    logic [2:0] occupancy;

    typedef struct {
        logic [2:0] index;
        logic       actual;
        logic       mis;
    } upd_t;

    upd_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    gshare_update_ctrl dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .pred_valid       (pred_valid),
        .pred_pc          (pred_pc),
        .pred_ready       (pred_ready),
        .pht_rd_index     (pht_rd_index),
        .pht_rd_counter   (pht_rd_counter),
        .pred_taken       (pred_taken),
        .res_valid        (res_valid),
        .res_taken        (res_taken),
        .mispredict       (mispredict),
        .pht_update_en    (pht_update_en),
        .pht_update_index (pht_update_index),
        .pht_actual       (pht_actual),
        .spec_ghr         (spec_ghr),
        .arch_ghr         (arch_ghr),
        .occupancy        (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic pv, input logic [2:0] pc, input logic [1:0] cnt,
                          input logic rv, input logic rt);
        pred_valid     = pv;
        pred_pc        = pc;
        pht_rd_counter = cnt;
        res_valid      = rv;
        res_taken      = rt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_upd(input logic [2:0] idx, input logic act, input logic mis);
        upd_t u;
        u.index  = idx;
        u.actual = act;
        u.mis    = mis;
        exp_q.push_back(u);
    endtask

    // Monitor: every update pulse must match the oldest expected update.
    always @(negedge clk) begin
        if (reset_n) begin
            if (pht_update_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_update: got index %0h actual %0h, none expected",
                             pht_update_index, pht_actual);
                end else begin
                    upd_t e;
                    e = exp_q.pop_front();
                    check("upd_index", 32'(pht_update_index), 32'(e.index));
                    check("upd_actual", 32'(pht_actual), 32'(e.actual));
                    check("upd_mispredict", 32'(mispredict), 32'(e.mis));
                end
            end else if (mispredict) begin
                checks++;
                errors++;
                $display("FAIL mispredict_without_update: got 1 required 0");
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        set_in(1'b0, 3'b000, 2'b00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_pred_ready", 32'(pred_ready), 32'd1);
        check("rst_spec_ghr", 32'(spec_ghr), 32'd0);
        check("rst_arch_ghr", 32'(arch_ghr), 32'd0);
        check("rst_update_en", 32'(pht_update_en), 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_mispredict", 32'(mispredict), 32'd0);

        // First prediction and its correct resolution.
        tick();
        set_in(1'b1, 3'b011, 2'b10, 1'b0, 1'b0);
        #1;
        check("p1_index", 32'(pht_rd_index), 32'h3);
        check("p1_taken", 32'(pred_taken), 32'd1);
        tick();
        set_in(1'b0, 3'b000, 2'b00, 1'b1, 1'b1);
        check("p1_spec_ghr", 32'(spec_ghr), 32'h1);
        check("p1_occupancy", 32'(occupancy), 32'd1);
        expect_upd(3'b011, 1'b1, 1'b0);
        #1;
        check("r1_pred_ready", 32'(pred_ready), 32'd1);
        tick();
        set_in(1'b0, 3'b000, 2'b00, 1'b0, 1'b0);
        check("r1_arch_ghr", 32'(arch_ghr), 32'h1);
        check("r1_occupancy", 32'(occupancy), 32'd0);
        check("r1_update_en", 32'(pht_update_en), 32'd1);
        check("r1_mispredict", 32'(mispredict), 32'd0);
        tick();
        check("r1_update_drop", 32'(pht_update_en), 32'd0);

        // Fill the queue: spec_ghr 001 -> 011 -> 110 -> 100 -> 001.
        set_in(1'b1, 3'b100, 2'b11, 1'b0, 1'b0);  // idx 101, pred 1
        #1 check("fa_index", 32'(pht_rd_index), 32'h5);
        tick();
        set_in(1'b1, 3'b010, 2'b00, 1'b0, 1'b0);  // idx 001, pred 0
        #1 check("fb_index", 32'(pht_rd_index), 32'h1);
        tick();
        set_in(1'b1, 3'b110, 2'b01, 1'b0, 1'b0);  // idx 000, pred 0
        #1 check("fc_index", 32'(pht_rd_index), 32'h0);
        tick();
        set_in(1'b1, 3'b000, 2'b10, 1'b0, 1'b0);  // idx 100, pred 1
        #1 check("fd_index", 32'(pht_rd_index), 32'h4);
        tick();
        check("full_occupancy", 32'(occupancy), 32'd4);
        check("full_spec_ghr", 32'(spec_ghr), 32'h1);
        set_in(1'b1, 3'b111, 2'b11, 1'b0, 1'b0);
        #1;
        check("full_pred_ready", 32'(pred_ready), 32'd0);
        check("full_index", 32'(pht_rd_index), 32'h6);
        tick();
        check("held_spec_ghr", 32'(spec_ghr), 32'h1);
        check("held_occupancy", 32'(occupancy), 32'd4);

        // Full with a correct pop: the push is still refused.
        set_in(1'b1, 3'b111, 2'b11, 1'b1, 1'b1);
        expect_upd(3'b101, 1'b1, 1'b0);
        #1 check("fullpop_pred_ready", 32'(pred_ready), 32'd0);
        tick();
        check("fullpop_occupancy", 32'(occupancy), 32'd3);
        check("fullpop_arch_ghr", 32'(arch_ghr), 32'h3);
        check("fullpop_spec_ghr", 32'(spec_ghr), 32'h1);

        // Simultaneous correct resolve and accept.
        set_in(1'b1, 3'b111, 2'b11, 1'b1, 1'b0);  // push idx 110 pred 1
        expect_upd(3'b001, 1'b0, 1'b0);
        #1 check("both_pred_ready", 32'(pred_ready), 32'd1);
        tick();
        check("both_occupancy", 32'(occupancy), 32'd3);
        check("both_spec_ghr", 32'(spec_ghr), 32'h3);
        check("both_arch_ghr", 32'(arch_ghr), 32'h6);

        // Mispredict: head idx 000 predicted not-taken, actually taken.
        set_in(1'b1, 3'b010, 2'b11, 1'b1, 1'b1);
        expect_upd(3'b000, 1'b1, 1'b1);
        #1 check("mis1_pred_ready", 32'(pred_ready), 32'd0);
        tick();
        set_in(1'b0, 3'b000, 2'b00, 1'b0, 1'b0);
        check("mis1_pulse", 32'(mispredict), 32'd1);
        check("mis1_occupancy", 32'(occupancy), 32'd0);
        check("mis1_spec_ghr", 32'(spec_ghr), 32'h5);
        check("mis1_arch_ghr", 32'(arch_ghr), 32'h5);
        tick();
        check("mis1_pulse_end", 32'(mispredict), 32'd0);

        // Second mispredict, taken prediction resolved not-taken.
        set_in(1'b1, 3'b001, 2'b11, 1'b0, 1'b0);  // idx 100, pred 1
        #1 check("p2_index", 32'(pht_rd_index), 32'h4);
        tick();
        check("p2_spec_ghr", 32'(spec_ghr), 32'h3);
        set_in(1'b0, 3'b000, 2'b00, 1'b1, 1'b0);
        expect_upd(3'b100, 1'b0, 1'b1);
        tick();
        set_in(1'b0, 3'b000, 2'b00, 1'b0, 1'b0);
        check("mis2_pulse", 32'(mispredict), 32'd1);
        check("mis2_spec_ghr", 32'(spec_ghr), 32'h2);
        check("mis2_arch_ghr", 32'(arch_ghr), 32'h2);
        tick();

        // Resolution against an empty queue is ignored.
        set_in(1'b0, 3'b000, 2'b00, 1'b1, 1'b1);
        tick();
        set_in(1'b0, 3'b000, 2'b00, 1'b0, 1'b0);
        check("empty_update_en", 32'(pht_update_en), 32'd0);
        check("empty_mispredict", 32'(mispredict), 32'd0);
        check("empty_arch_ghr", 32'(arch_ghr), 32'h2);
        check("empty_spec_ghr", 32'(spec_ghr), 32'h2);

        // Three in flight plus a pending update, then async reset.
        set_in(1'b1, 3'b000, 2'b10, 1'b0, 1'b0);  // idx 010
        tick();
        set_in(1'b1, 3'b000, 2'b10, 1'b0, 1'b0);  // idx 101
        tick();
        set_in(1'b1, 3'b000, 2'b00, 1'b0, 1'b0);  // idx 011
        tick();
        set_in(1'b1, 3'b000, 2'b11, 1'b1, 1'b1);  // pop idx 010, push idx 110
        tick();
        set_in(1'b0, 3'b000, 2'b00, 1'b0, 1'b0);
        check("pre_rst_occupancy", 32'(occupancy), 32'd3);
        check("pre_rst_update_en", 32'(pht_update_en), 32'd1);
        check("pre_rst_update_index", 32'(pht_update_index), 32'h2);
        #2 reset_n = 1'b0;
        #1;
        check("async_occupancy", 32'(occupancy), 32'd0);
        check("async_update_en", 32'(pht_update_en), 32'd0);
        check("async_spec_ghr", 32'(spec_ghr), 32'd0);
        check("async_arch_ghr", 32'(arch_ghr), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) tick();
        check("pending_updates", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
